xdma_dsc_byp_gen: RTL and testbench



---
 rtl/xdma_dsc_pkg.sv | 46 ++++
 rtl/xdma_dsc_req_fifo.sv | 61 ++++++
 rtl/xdma_dsc_byp_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_xdma_dsc_byp_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_dsc_pkg.sv
// Shared types and constants for the XDMA descriptor-bypass generator.
// The optional statistics feature is enabled with DSC_BYP_STATS_EN.
package xdma_dsc_pkg;

    localparam int unsigned PAGE_BYTES   = 4096;
    localparam int unsigned CTL_STOP_BIT = 0;
    localparam int unsigned CTL_CMPL_BIT = 1;
    localparam logic [15:0] CTL_FINAL    = (16'd1 << CTL_STOP_BIT) | (16'd1 << CTL_CMPL_BIT);

    typedef struct packed {
        logic        is_c2h;
        logic [63:0] src;
        logic [63:0] dst;
        logic [27:0] len;
    } dsc_req_t;

    localparam int unsigned REQ_W = $bits(dsc_req_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2
    } dsc_state_e;

    // Chunk never crosses a 4 KiB host page and never exceeds max_len.
    function automatic logic [27:0] chunk_len(input logic [27:0] rem,
                                              input logic [11:0] host_lo,
                                              input logic [28:0] max_len);
        logic [28:0] room;
        logic [28:0] len;
        room = 29'(PAGE_BYTES) - {17'd0, host_lo};
        len  = {1'b0, rem};
        if (room < len) begin
            len = room;
        end else begin
            len = len;
        end
        if (max_len < len) begin
            len = max_len;
        end else begin
            len = len;
        end
        return len[27:0];
    endfunction

endpackage

// File: rtl/xdma_dsc_req_fifo.sv
// Request queue: synchronous FIFO with the head word held in registers,
// full/empty flags and a fill level. Accepts a write when full if a read happens too.
module xdma_dsc_req_fifo
    import xdma_dsc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [REQ_W-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [REQ_W-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [REQ_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_ok, rd_ok;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == {(AW+1){1'b0}});
    assign wr_ok   = wr_en & (~full | rd_en);
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = cnt_q;

    // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d = rd_ptr_q + AW'(rd_ok);
        cnt_d    = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {(AW+1){1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {REQ_W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/xdma_dsc_byp_gen.sv
// Splits queued DMA requests into page-bounded XDMA bypass descriptors.
// Define DSC_BYP_STATS_EN to add per-direction accepted-descriptor counters.
module xdma_dsc_byp_gen
    import xdma_dsc_pkg::*;
#(
    parameter int unsigned MAX_DSC_LEN    = 4096,
    parameter int unsigned REQ_FIFO_DEPTH = 4
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_c2h,
    input  logic [63:0] req_src_addr,
    input  logic [63:0] req_dst_addr,
    input  logic [27:0] req_len,
    output logic        h2c_dsc_byp_load,
    output logic [63:0] h2c_dsc_byp_src_addr,
    output logic [63:0] h2c_dsc_byp_dst_addr,
    output logic [27:0] h2c_dsc_byp_len,
    output logic [15:0] h2c_dsc_byp_ctl,
    input  logic        h2c_dsc_byp_ready,
    output logic        c2h_dsc_byp_load,
    output logic [63:0] c2h_dsc_byp_src_addr,
    output logic [63:0] c2h_dsc_byp_dst_addr,
    output logic [27:0] c2h_dsc_byp_len,
    output logic [15:0] c2h_dsc_byp_ctl,
    input  logic        c2h_dsc_byp_ready,
    output logic        busy,
    output logic        err_zero_len
`ifdef DSC_BYP_STATS_EN
    ,
    output logic [31:0] stat_h2c_dsc,
    output logic [31:0] stat_c2h_dsc
`endif
);

    localparam int unsigned LVL_W = $clog2(REQ_FIFO_DEPTH) + 1;

    dsc_state_e       state_q, state_d;
    logic             is_c2h_q, is_c2h_d;
    logic [63:0]      src_q, src_d, dst_q, dst_d;
    logic [27:0]      rem_q, rem_d;
    logic [63:0]      dsc_src_q, dsc_src_d, dsc_dst_q, dsc_dst_d;
    logic [27:0]      dsc_len_q, dsc_len_d;
    logic [15:0]      dsc_ctl_q, dsc_ctl_d;
    logic             h2c_load_q, h2c_load_d, c2h_load_q, c2h_load_d;
    logic             busy_q, busy_d, err_q, err_d, rdy_en_q;
    logic             take_chunk, clear_dsc;
    logic [REQ_W-1:0] fifo_rdata, fifo_wdata;
    dsc_req_t         fifo_head;
    logic             fifo_full, fifo_empty, push, pop, accept;
    logic [LVL_W-1:0] fifo_level, level_next;
    logic             sel_c2h;
    logic [63:0]      sel_src, sel_dst;
    logic [27:0]      sel_rem, chunk;

    assign fifo_wdata = {req_is_c2h, req_src_addr, req_dst_addr, req_len};
    assign fifo_head  = fifo_rdata;
    assign pop        = (state_q == ST_LOAD);
    // A full queue still accepts in the cycle the head is popped.
    assign req_ready  = rdy_en_q & (~fifo_full | pop);
    assign push       = req_valid & req_ready;
    assign accept     = (h2c_load_q & h2c_dsc_byp_ready) | (c2h_load_q & c2h_dsc_byp_ready);
    assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

    xdma_dsc_req_fifo #(.DEPTH(REQ_FIFO_DEPTH)) u_req_fifo (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .wr_en   (push),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The first chunk comes straight from the queue head, later ones from the working registers.
    assign sel_c2h = pop ? fifo_head.is_c2h : is_c2h_q;
    assign sel_src = pop ? fifo_head.src    : src_q;
    assign sel_dst = pop ? fifo_head.dst    : dst_q;
    assign sel_rem = pop ? fifo_head.len    : rem_q;
    assign chunk   = chunk_len(sel_rem, sel_c2h ? sel_dst[11:0] : sel_src[11:0], 29'(MAX_DSC_LEN));

    // Next-state and descriptor-output logic.
    always_comb begin
        state_d    = state_q;
        is_c2h_d   = is_c2h_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        dsc_src_d  = dsc_src_q;
        dsc_dst_d  = dsc_dst_q;
        dsc_len_d  = dsc_len_q;
        dsc_ctl_d  = dsc_ctl_q;
        h2c_load_d = h2c_load_q;
        c2h_load_d = c2h_load_q;
        err_d      = err_q;
        take_chunk = 1'b0;
        clear_dsc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (fifo_head.len == 28'd0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    take_chunk = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept && (rem_q == 28'd0)) begin
                    clear_dsc = 1'b1;
                    state_d   = ST_IDLE;
                end else if (accept) begin
                    take_chunk = 1'b1;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_chunk) begin
            is_c2h_d   = sel_c2h;
            src_d      = sel_src + {36'd0, chunk};
            dst_d      = sel_dst + {36'd0, chunk};
            rem_d      = sel_rem - chunk;
            dsc_src_d  = sel_src;
            dsc_dst_d  = sel_dst;
            dsc_len_d  = chunk;
            dsc_ctl_d  = (sel_rem == chunk) ? CTL_FINAL : 16'd0;
            h2c_load_d = ~sel_c2h;
            c2h_load_d = sel_c2h;
        end else if (clear_dsc) begin
            dsc_src_d  = 64'd0;
            dsc_dst_d  = 64'd0;
            dsc_len_d  = 28'd0;
            dsc_ctl_d  = 16'd0;
            h2c_load_d = 1'b0;
            c2h_load_d = 1'b0;
        end else begin
            dsc_len_d = dsc_len_q;
        end

        busy_d = (state_d != ST_IDLE) | (level_next != {LVL_W{1'b0}});
    end

    // State, working and output registers.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q    <= ST_IDLE;
            is_c2h_q   <= 1'b0;
            src_q      <= 64'd0;
            dst_q      <= 64'd0;
            rem_q      <= 28'd0;
            dsc_src_q  <= 64'd0;
            dsc_dst_q  <= 64'd0;
            dsc_len_q  <= 28'd0;
            dsc_ctl_q  <= 16'd0;
            h2c_load_q <= 1'b0;
            c2h_load_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_c2h_q   <= is_c2h_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            dsc_src_q  <= dsc_src_d;
            dsc_dst_q  <= dsc_dst_d;
            dsc_len_q  <= dsc_len_d;
            dsc_ctl_q  <= dsc_ctl_d;
            h2c_load_q <= h2c_load_d;
            c2h_load_q <= c2h_load_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rdy_en_q   <= 1'b1;
        end
    end

    assign h2c_dsc_byp_load     = h2c_load_q;
    assign h2c_dsc_byp_src_addr = dsc_src_q;
    assign h2c_dsc_byp_dst_addr = dsc_dst_q;
    assign h2c_dsc_byp_len      = dsc_len_q;
    assign h2c_dsc_byp_ctl      = dsc_ctl_q;
    assign c2h_dsc_byp_load     = c2h_load_q;
    assign c2h_dsc_byp_src_addr = dsc_src_q;
    assign c2h_dsc_byp_dst_addr = dsc_dst_q;
    assign c2h_dsc_byp_len      = dsc_len_q;
    assign c2h_dsc_byp_ctl      = dsc_ctl_q;
    assign busy                 = busy_q;
    assign err_zero_len         = err_q;

`ifdef DSC_BYP_STATS_EN
    logic [31:0] stat_h2c_q, stat_h2c_d, stat_c2h_q, stat_c2h_d;

    // Accepted-descriptor counters, wrapping at 2^32.
    always_comb begin
        stat_h2c_d = stat_h2c_q + {31'd0, h2c_load_q & h2c_dsc_byp_ready};
        stat_c2h_d = stat_c2h_q + {31'd0, c2h_load_q & c2h_dsc_byp_ready};
    end

    // Counter registers.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            stat_h2c_q <= 32'd0;
            stat_c2h_q <= 32'd0;
        end else begin
            stat_h2c_q <= stat_h2c_d;
            stat_c2h_q <= stat_c2h_d;
        end
    end

    assign stat_h2c_dsc = stat_h2c_q;
    assign stat_c2h_dsc = stat_c2h_q;
`endif

endmodule

// File: tb/tb_xdma_dsc_byp_gen.sv
// Directed self-checking bench for xdma_dsc_byp_gen (default parameters).
module tb_xdma_dsc_byp_gen;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_c2h = 1'b0;
    logic [63:0] req_src_addr = 64'd0;
    logic [63:0] req_dst_addr = 64'd0;
    logic [27:0] req_len = 28'd0;
    logic        h2c_dsc_byp_load;
    logic [63:0] h2c_dsc_byp_src_addr, h2c_dsc_byp_dst_addr;
    logic [27:0] h2c_dsc_byp_len;
    logic [15:0] h2c_dsc_byp_ctl;
    logic        h2c_dsc_byp_ready = 1'b0;
    logic        c2h_dsc_byp_load;
    logic [63:0] c2h_dsc_byp_src_addr, c2h_dsc_byp_dst_addr;
    logic [27:0] c2h_dsc_byp_len;
    logic [15:0] c2h_dsc_byp_ctl;
    logic        c2h_dsc_byp_ready = 1'b0;
    logic        busy, err_zero_len;
`ifdef DSC_BYP_STATS_EN
    logic [31:0] stat_h2c_dsc, stat_c2h_dsc;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int acc_h2c  = 0;
    int acc_c2h  = 0;
    int snap;

    xdma_dsc_byp_gen dut (
        .axi_aclk             (axi_aclk),
        .axi_aresetn          (axi_aresetn),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_is_c2h           (req_is_c2h),
        .req_src_addr         (req_src_addr),
        .req_dst_addr         (req_dst_addr),
        .req_len              (req_len),
        .h2c_dsc_byp_load     (h2c_dsc_byp_load),
        .h2c_dsc_byp_src_addr (h2c_dsc_byp_src_addr),
        .h2c_dsc_byp_dst_addr (h2c_dsc_byp_dst_addr),
        .h2c_dsc_byp_len      (h2c_dsc_byp_len),
        .h2c_dsc_byp_ctl      (h2c_dsc_byp_ctl),
        .h2c_dsc_byp_ready    (h2c_dsc_byp_ready),
        .c2h_dsc_byp_load     (c2h_dsc_byp_load),
        .c2h_dsc_byp_src_addr (c2h_dsc_byp_src_addr),
        .c2h_dsc_byp_dst_addr (c2h_dsc_byp_dst_addr),
        .c2h_dsc_byp_len      (c2h_dsc_byp_len),
        .c2h_dsc_byp_ctl      (c2h_dsc_byp_ctl),
        .c2h_dsc_byp_ready    (c2h_dsc_byp_ready),
        .busy                 (busy),
        .err_zero_len         (err_zero_len)
`ifdef DSC_BYP_STATS_EN
        ,
        .stat_h2c_dsc         (stat_h2c_dsc),
        .stat_c2h_dsc         (stat_c2h_dsc)
`endif
    );

    always #5 axi_aclk = ~axi_aclk;

    // Count descriptor acceptances as seen on the bus.
    always @(posedge axi_aclk) begin
        if (h2c_dsc_byp_load && h2c_dsc_byp_ready) acc_h2c <= acc_h2c + 1;
        if (c2h_dsc_byp_load && c2h_dsc_byp_ready) acc_c2h <= acc_c2h + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic c2h, input logic [63:0] src, input logic [63:0] dst,
                        input logic [27:0] len);
        int t = 0;
        req_valid    = 1'b1;
        req_is_c2h   = c2h;
        req_src_addr = src;
        req_dst_addr = dst;
        req_len      = len;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge axi_aclk);
            t++;
        end
        if (t >= 50) check("push_timeout", {63'd0, req_ready}, 64'd1);
        @(negedge axi_aclk);
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for the direction's load, then checks the descriptor fields.
    task automatic get_dsc(input string tag, input logic c2h, input logic [63:0] src,
                           input logic [63:0] dst, input logic [27:0] len, input logic [15:0] ctl);
        int t = 0;
        while (((c2h ? c2h_dsc_byp_load : h2c_dsc_byp_load) !== 1'b1) && t < 100) begin
            @(negedge axi_aclk);
            t++;
        end
        if (c2h) begin
            check({tag, "_load"},  {63'd0, c2h_dsc_byp_load}, 64'd1);
            check({tag, "_other"}, {63'd0, h2c_dsc_byp_load}, 64'd0);
            check({tag, "_src"},   c2h_dsc_byp_src_addr, src);
            check({tag, "_dst"},   c2h_dsc_byp_dst_addr, dst);
            check({tag, "_len"},   {36'd0, c2h_dsc_byp_len}, {36'd0, len});
            check({tag, "_ctl"},   {48'd0, c2h_dsc_byp_ctl}, {48'd0, ctl});
        end else begin
            check({tag, "_load"},  {63'd0, h2c_dsc_byp_load}, 64'd1);
            check({tag, "_other"}, {63'd0, c2h_dsc_byp_load}, 64'd0);
            check({tag, "_src"},   h2c_dsc_byp_src_addr, src);
            check({tag, "_dst"},   h2c_dsc_byp_dst_addr, dst);
            check({tag, "_len"},   {36'd0, h2c_dsc_byp_len}, {36'd0, len});
            check({tag, "_ctl"},   {48'd0, h2c_dsc_byp_ctl}, {48'd0, ctl});
        end
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge axi_aclk);
        check("rst_h2c_load", {63'd0, h2c_dsc_byp_load}, 64'd0);
        check("rst_c2h_load", {63'd0, c2h_dsc_byp_load}, 64'd0);
        check("rst_len",      {36'd0, h2c_dsc_byp_len}, 64'd0);
        check("rst_busy",     {63'd0, busy}, 64'd0);
        check("rst_err",      {63'd0, err_zero_len}, 64'd0);
        check("rst_ready",    {63'd0, req_ready}, 64'd0);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        check("rel_ready", {63'd0, req_ready}, 64'd1);

        // Single H2C descriptor, ready held high
        h2c_dsc_byp_ready = 1'b1;
        push(1'b0, 64'h1000, 64'h0, 28'h800);
        get_dsc("h2c1", 1'b0, 64'h1000, 64'h0, 28'h800, 16'h0003);
        @(negedge axi_aclk);
        check("h2c1_load_1cyc", {63'd0, h2c_dsc_byp_load}, 64'd0);
        check("h2c1_idle_busy", {63'd0, busy}, 64'd0);
        check("h2c1_acc", 64'(acc_h2c), 64'd1);

        // C2H split at page boundaries, back-to-back chunks
        c2h_dsc_byp_ready = 1'b1;
        push(1'b1, 64'hA000_0000, 64'h0FF0, 28'h2000);
        get_dsc("c2h_c1", 1'b1, 64'hA000_0000, 64'h0FF0, 28'h010, 16'h0000);
        @(negedge axi_aclk);
        get_dsc("c2h_c2", 1'b1, 64'hA000_0010, 64'h1000, 28'h1000, 16'h0000);
        @(negedge axi_aclk);
        get_dsc("c2h_c3", 1'b1, 64'hA000_1010, 64'h2000, 28'hFF0, 16'h0003);
        @(negedge axi_aclk);
        check("c2h_done_load", {63'd0, c2h_dsc_byp_load}, 64'd0);
        check("c2h_acc", 64'(acc_c2h), 64'd3);

        // Back-pressure: ready low for 10 cycles, fields stable, then one acceptance
        c2h_dsc_byp_ready = 1'b0;
        push(1'b1, 64'h5000, 64'h3000, 28'h100);
        get_dsc("bp", 1'b1, 64'h5000, 64'h3000, 28'h100, 16'h0003);
        for (int i = 0; i < 10; i++) begin
            @(negedge axi_aclk);
            check("bp_hold_load", {63'd0, c2h_dsc_byp_load}, 64'd1);
            check("bp_hold_len",  {36'd0, c2h_dsc_byp_len}, 64'h100);
            check("bp_hold_dst",  c2h_dsc_byp_dst_addr, 64'h3000);
        end
        snap = acc_c2h;
        c2h_dsc_byp_ready = 1'b1;
        @(negedge axi_aclk);
        check("bp_released_load", {63'd0, c2h_dsc_byp_load}, 64'd0);
        repeat (3) @(negedge axi_aclk);
        check("bp_one_accept", 64'(acc_c2h), 64'(snap + 1));

        // Queue fill: five requests with descriptor ready low
        h2c_dsc_byp_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push(1'b0, 64'h10000 * 64'(k), 64'h0, 28'h40 * 28'(k));
        end
        check("fill_ready_low", {63'd0, req_ready}, 64'd0);
        check("fill_busy", {63'd0, busy}, 64'd1);
        h2c_dsc_byp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            get_dsc("fill", 1'b0, 64'h10000 * 64'(k), 64'h0, 28'h40 * 28'(k), 16'h0003);
            @(negedge axi_aclk);
        end
        repeat (3) @(negedge axi_aclk);
        check("fill_ready_back", {63'd0, req_ready}, 64'd1);
        check("fill_busy_done", {63'd0, busy}, 64'd0);

        // Zero-length request is discarded and flagged
        check("zl_err_before", {63'd0, err_zero_len}, 64'd0);
        snap = acc_h2c;
        push(1'b0, 64'h7000, 64'h0, 28'h0);
        push(1'b0, 64'h8000, 64'h0, 28'h40);
        get_dsc("zl", 1'b0, 64'h8000, 64'h0, 28'h40, 16'h0003);
        repeat (4) @(negedge axi_aclk);
        check("zl_err", {63'd0, err_zero_len}, 64'd1);
        check("zl_one_dsc", 64'(acc_h2c), 64'(snap + 1));

        // Reset during chunk 2; source address also wraps past 2^64
        push(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0FF0, 28'h2000);
        get_dsc("wr_c1", 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0FF0, 28'h010, 16'h0000);
        @(negedge axi_aclk);
        get_dsc("wr_c2", 1'b1, 64'h0, 64'h1000, 28'h1000, 16'h0000);
        axi_aresetn = 1'b0;
        @(negedge axi_aclk);
        check("mrst_c2h_load", {63'd0, c2h_dsc_byp_load}, 64'd0);
        check("mrst_h2c_load", {63'd0, h2c_dsc_byp_load}, 64'd0);
        check("mrst_src",      c2h_dsc_byp_src_addr, 64'd0);
        check("mrst_dst",      c2h_dsc_byp_dst_addr, 64'd0);
        check("mrst_len",      {36'd0, c2h_dsc_byp_len}, 64'd0);
        check("mrst_ctl",      {48'd0, c2h_dsc_byp_ctl}, 64'd0);
        check("mrst_busy",     {63'd0, busy}, 64'd0);
        check("mrst_err",      {63'd0, err_zero_len}, 64'd0);
        check("mrst_ready",    {63'd0, req_ready}, 64'd0);
        snap = acc_c2h;
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        check("mrst_rel_ready", {63'd0, req_ready}, 64'd1);
        check("mrst_rel_load",  {63'd0, c2h_dsc_byp_load}, 64'd0);
        repeat (10) @(negedge axi_aclk);
        check("mrst_no_more", 64'(acc_c2h), 64'(snap));
        check("mrst_idle_busy", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
